// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: physical pointer, data word and queue entry.
// Also holds the little-endian byte-lane extraction used by load forwarding.
package store_buffer_pkg;

    localparam int unsigned PPTR_W = 20;
    localparam int unsigned WORD_W = 32;

    typedef logic [PPTR_W-1:0] pptr_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic  valid;
        logic  isbyte;
        pptr_t addr;
        word_t data;
    } sb_entry_t;

    function automatic word_t byte_lane(input word_t w, input logic [1:0] lane);
        word_t r;
        r = '0;
        case (lane)
            2'd0: r[7:0] = w[7:0];
            2'd1: r[7:0] = w[15:8];
            2'd2: r[7:0] = w[23:16];
            default: r[7:0] = w[31:24];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding search over the pending store queue.
// The youngest matching entry decides hit, data or conflict.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  sb_entry_t        i_entries [DEPTH],
    input  logic [PTR_W-1:0] i_head,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_ld_en,
    input  pptr_t            i_ld_addr,
    input  logic             i_ld_isbyte,
    output logic             o_hit,
    output word_t            o_data,
    output logic             o_conflict
);

    logic [PTR_W-1:0] w_idx;
    logic             w_done;
    sb_entry_t        w_e;

    // k = 0 is the youngest entry (tail-1); a byte entry in a different lane
    // of the same word does not stop the search.
    always_comb begin
        o_hit      = 1'b0;
        o_data     = '0;
        o_conflict = 1'b0;
        w_idx      = '0;
        w_done     = 1'b0;
        w_e        = '0;
        if (i_ld_en) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                w_idx = i_head + PTR_W'(i_count) - PTR_W'(k) - PTR_W'(1);
                w_e   = i_entries[w_idx];
                if (!w_done && (k < 32'(i_count)) && w_e.valid &&
                    (w_e.addr[PPTR_W-1:2] == i_ld_addr[PPTR_W-1:2])) begin
                    if (!w_e.isbyte) begin
                        o_hit  = 1'b1;
                        o_data = i_ld_isbyte ? byte_lane(w_e.data, i_ld_addr[1:0]) : w_e.data;
                        w_done = 1'b1;
                    end else if (!i_ld_isbyte) begin
                        o_conflict = 1'b1;
                        w_done     = 1'b1;
                    end else if (w_e.addr[1:0] == i_ld_addr[1:0]) begin
                        o_hit  = 1'b1;
                        o_data = {{(WORD_W-8){1'b0}}, w_e.data[7:0]};
                        w_done = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order queue of committed stores draining into the d-cache write port,
// with store-to-load forwarding for TL-stage loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = PPTR_W,
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store_en,
    input  logic                     store_isbyte,
    input  logic [ADDR_W-1:0]        store_addr,
    input  logic [DATA_W-1:0]        store_data,
    output logic                     full,
    output logic                     overflow,
    output logic                     drain_valid,
    input  logic                     drain_ready,
    output logic [ADDR_W-1:0]        drain_addr,
    output logic [DATA_W-1:0]        drain_data,
    output logic                     drain_isbyte,
    input  logic                     ld_en,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic                     ld_isbyte,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_conflict,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        r_entries [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    sb_entry_t        w_head_e;
    word_t            w_store_data;

    assign w_head_e     = r_entries[r_head];
    assign full         = (r_count == CNT_W'(DEPTH));
    assign drain_valid  = (r_count != '0);
    assign drain_addr   = w_head_e.addr;
    assign drain_data   = w_head_e.data;
    assign drain_isbyte = w_head_e.isbyte;
    assign overflow     = r_overflow;
    assign count        = r_count;

    // full is taken before any same-cycle pop, so a push at DEPTH is refused.
    assign w_push       = store_en && !full;
    assign w_pop        = drain_valid && drain_ready;
    assign w_store_data = store_isbyte ? {{(DATA_W-8){1'b0}}, store_data[7:0]} : store_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_entries[r_tail] <= '{valid: 1'b1, isbyte: store_isbyte,
                                       addr: store_addr, data: w_store_data};
                r_tail            <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (store_en && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sb_fwd_match #(
        .DEPTH(DEPTH)
    ) u_fwd (
        .i_entries  (r_entries),
        .i_head     (r_head),
        .i_count    (r_count),
        .i_ld_en    (ld_en),
        .i_ld_addr  (ld_addr),
        .i_ld_isbyte(ld_isbyte),
        .o_hit      (ld_hit),
        .o_data     (ld_data),
        .o_conflict (ld_conflict)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: push/drain order, overflow,
// forwarding outcomes, wrap under steady push+pop, and reset.
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        store_en;
    logic        store_isbyte;
    logic [19:0] store_addr;
    logic [31:0] store_data;
    logic        full;
    logic        overflow;
    logic        drain_valid;
    logic        drain_ready;
    logic [19:0] drain_addr;
    logic [31:0] drain_data;
    logic        drain_isbyte;
    logic        ld_en;
    logic [19:0] ld_addr;
    logic        ld_isbyte;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_conflict;
    logic [2:0]  count;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic [31:0] exp_q[$];

    store_buffer #(
        .DEPTH (4),
        .ADDR_W(20),
        .DATA_W(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .store_en    (store_en),
        .store_isbyte(store_isbyte),
        .store_addr  (store_addr),
        .store_data  (store_data),
        .full        (full),
        .overflow    (overflow),
        .drain_valid (drain_valid),
        .drain_ready (drain_ready),
        .drain_addr  (drain_addr),
        .drain_data  (drain_data),
        .drain_isbyte(drain_isbyte),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_isbyte   (ld_isbyte),
        .ld_hit      (ld_hit),
        .ld_data     (ld_data),
        .ld_conflict (ld_conflict),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic isb, input logic [19:0] a, input logic [31:0] d);
        store_en     = 1'b1;
        store_isbyte = isb;
        store_addr   = a;
        store_data   = d;
    endtask

    task automatic ld(input logic isb, input logic [19:0] a);
        ld_en     = 1'b1;
        ld_isbyte = isb;
        ld_addr   = a;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; store_en = 1'b0; store_isbyte = 1'b0; store_addr = '0;
        store_data = '0; drain_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_isbyte = 1'b0;
        tick(); tick();
        rst = 1'b0;
        ld(1'b0, 20'h00100);
        chk("rst_full", 32'(full), 0);
        chk("rst_dvalid", 32'(drain_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_hit", 32'(ld_hit), 0);
        chk("rst_conf", 32'(ld_conflict), 0);

        // word store, then forwarding; same-cycle store is not yet visible
        st(1'b0, 20'h00100, 32'hDEADBEEF);
        ld(1'b0, 20'h00100);
        chk("samecyc_hit", 32'(ld_hit), 0);
        tick();
        store_en = 1'b0;
        ld(1'b0, 20'h00100);
        chk("w_hit", 32'(ld_hit), 1);
        chk("w_data", ld_data, 32'hDEADBEEF);
        chk("w_dvalid", 32'(drain_valid), 1);
        chk("w_count", 32'(count), 1);
        ld(1'b1, 20'h00101);
        chk("wb_data", ld_data, 32'h000000BE);
        ld(1'b1, 20'h00103);
        chk("wb3_data", ld_data, 32'h000000DE);
        drain_ready = 1'b1;
        tick();
        drain_ready = 1'b0;
        chk("w_drained", 32'(count), 0);

        // fill, overflow, ordered drain
        for (int i = 0; i < 4; i++) begin
            st(1'b0, 20'h00400 + 20'(4 * i), 32'hA0 + 32'(i));
            tick();
        end
        store_en = 1'b0;
        #1;
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 4);
        st(1'b0, 20'h00500, 32'hBAD0BAD0);
        tick();
        store_en = 1'b0;
        #1;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_head", drain_data, 32'hA0);
        drain_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(drain_valid), 1);
            chk("drain_data", drain_data, 32'hA0 + 32'(i));
            chk("drain_addr", 32'(drain_addr), 32'h00400 + 32'(4 * i));
            tick();
        end
        chk("drain_empty", 32'(drain_valid), 0);
        chk("drain_nfull", 32'(full), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        drain_ready = 1'b0;

        // byte store forwarding
        st(1'b1, 20'h00102, 32'h123456AB);
        tick();
        store_en = 1'b0;
        chk("b_drain_data", drain_data, 32'h000000AB);
        chk("b_drain_isb", 32'(drain_isbyte), 1);
        ld(1'b0, 20'h00100);
        chk("b_wl_conf", 32'(ld_conflict), 1);
        chk("b_wl_hit", 32'(ld_hit), 0);
        ld(1'b1, 20'h00102);
        chk("b_bl_hit", 32'(ld_hit), 1);
        chk("b_bl_data", ld_data, 32'h000000AB);
        chk("b_bl_conf", 32'(ld_conflict), 0);
        ld(1'b1, 20'h00101);
        chk("b_lane_hit", 32'(ld_hit), 0);
        chk("b_lane_conf", 32'(ld_conflict), 0);
        chk("b_lane_data", ld_data, 0);
        drain_ready = 1'b1;
        tick();
        drain_ready = 1'b0;

        // older word under a younger byte in another lane still forwards
        st(1'b0, 20'h00600, 32'hCAFEF00D);
        tick();
        st(1'b1, 20'h00603, 32'h00000077);
        tick();
        store_en = 1'b0;
        ld(1'b1, 20'h00601);
        chk("skip_hit", 32'(ld_hit), 1);
        chk("skip_data", ld_data, 32'h000000F0);
        ld(1'b1, 20'h00603);
        chk("young_byte", ld_data, 32'h00000077);
        drain_ready = 1'b1;
        tick(); tick();
        drain_ready = 1'b0;

        // youngest word wins
        st(1'b0, 20'h00200, 32'h11223344);
        tick();
        st(1'b0, 20'h00200, 32'h55667788);
        tick();
        store_en = 1'b0;
        ld(1'b1, 20'h00203);
        chk("yw_hit", 32'(ld_hit), 1);
        chk("yw_data", ld_data, 32'h00000055);
        ld(1'b0, 20'h00200);
        chk("yw_word", ld_data, 32'h55667788);
        ld_en = 1'b0;
        #1;
        chk("ld_off_data", ld_data, 0);

        // steady push+pop at count=2
        exp_q.push_back(32'h11223344);
        exp_q.push_back(32'h55667788);
        drain_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            st(1'b0, 20'h00300 + 20'(4 * i), 32'hC0DE0000 + 32'(i));
            #1;
            chk("pp_count", 32'(count), 2);
            chk("pp_data", drain_data, exp_q[0]);
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(32'hC0DE0000 + 32'(i));
        end
        store_en = 1'b0;
        drain_ready = 1'b0;
        #1;
        chk("pp_end_count", 32'(count), 2);
        chk("pp_end_head", drain_data, exp_q[0]);

        // reset with pending entries
        st(1'b0, 20'h00700, 32'h01020304);
        tick();
        store_en = 1'b0;
        chk("pre_rst_count", 32'(count), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_count", 32'(count), 0);
        chk("rst2_dvalid", 32'(drain_valid), 0);
        chk("rst2_full", 32'(full), 0);
        chk("rst2_ovf", 32'(overflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
